// File: rtl/multi_channel_programmable_delay.sv
// multi_channel_programmable_delay
// Delays CHANNELS packed sample lanes plus a valid flag by a runtime-programmable
// number of clocks (1..MAX_DELAY). All lanes share one circular buffer and one
// write pointer, so they stay sample-aligned. A delay change is acknowledged
// with a one-cycle pulse and followed by a flush that masks stale buffer data.
// Optional feature macro: DELAY_BYPASS_EN adds a BYPASS input that selects a
// single-register path around the buffer.
module multi_channel_programmable_delay #(
    parameter  int WIDTH         = 8,
    parameter  int CHANNELS      = 2,
    parameter  int MAX_DELAY     = 16,
    parameter  int DEFAULT_DELAY = 10,
    localparam int DLY_W         = $clog2(MAX_DELAY + 1)
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [CHANNELS*WIDTH-1:0] DIN,
    input  logic                      DIN_VALID,
    input  logic [DLY_W-1:0]          DELAY_SET,
    input  logic                      DELAY_LOAD,
`ifdef DELAY_BYPASS_EN
    input  logic                      BYPASS,
`endif
    output logic                      DELAY_ACK,
    output logic [CHANNELS*WIDTH-1:0] DOUT,
    output logic                      DOUT_VALID,
    output logic [DLY_W-1:0]          DELAY_CUR,
    output logic                      BUSY
);

    localparam int DW    = CHANNELS * WIDTH;
    localparam int EW    = DW + 1;
    localparam int PTR_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    logic [EW-1:0]    mem_q [MAX_DELAY];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_addr;
    logic [EW-1:0]    rd_data;
    logic [DLY_W-1:0] dly_clamped;

    state_t           state_q;
    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] dly_q;
    logic             ack_q;
    logic [DW-1:0]    dout_q;
    logic             dout_valid_q;

    // Clamp the requested delay into 1..MAX_DELAY.
    always_comb begin
        dly_clamped = DELAY_SET;
        if (DELAY_SET == '0) begin
            dly_clamped = DLY_W'(1);
        end else if (DELAY_SET > DLY_W'(MAX_DELAY)) begin
            dly_clamped = DLY_W'(MAX_DELAY);
        end
    end

    // Pointer arithmetic with explicit modulo wrap (depth need not be a power of 2).
    // wr_ptr_q is the slot written on the coming edge, so the sample taken D edges
    // earlier sits D slots behind it; for D = MAX_DELAY that is the slot about to be
    // overwritten, read before the write lands.
    always_comb begin
        int unsigned wp;
        int unsigned d;
        int unsigned ra;
        wp = int'(wr_ptr_q);
        d  = int'(dly_q);
        if (wp >= d) begin
            ra = wp - d;
        end else begin
            ra = wp + MAX_DELAY - d;
        end
        rd_addr  = PTR_W'(ra);
        rd_data  = mem_q[rd_addr];
        wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_DELAY - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    // Circular buffer: one {valid, data} entry written every clock.
    always_ff @(posedge CLK) begin
        mem_q[wr_ptr_q] <= {DIN_VALID, DIN};
    end

    // Control FSM, write pointer and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_FLUSH;
            cnt_q        <= DLY_W'(DEFAULT_DELAY);
            dly_q        <= DLY_W'(DEFAULT_DELAY);
            ack_q        <= 1'b0;
            wr_ptr_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            ack_q    <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (DELAY_LOAD) begin
                        ack_q   <= 1'b1;
                        dly_q   <= dly_clamped;
                        cnt_q   <= dly_clamped;
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    cnt_q <= cnt_q - DLY_W'(1);
                    if (cnt_q == DLY_W'(1)) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_FLUSH;
            endcase
`ifdef DELAY_BYPASS_EN
            if (BYPASS) begin
                dout_q       <= DIN;
                dout_valid_q <= DIN_VALID;
            end else
`endif
            if (state_q == ST_FLUSH) begin
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                dout_q       <= rd_data[DW-1:0];
                dout_valid_q <= rd_data[EW-1];
            end
        end
    end

    assign DELAY_ACK  = ack_q;
    assign DOUT       = dout_q;
    assign DOUT_VALID = dout_valid_q;
    assign DELAY_CUR  = dly_q;
    assign BUSY       = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_multi_channel_programmable_delay.sv
// Self-checking bench for multi_channel_programmable_delay (default parameters).
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
// Build with DELAY_BYPASS_EN defined to also exercise the bypass path.
module tb_multi_channel_programmable_delay;

    localparam int WIDTH         = 8;
    localparam int CHANNELS      = 2;
    localparam int MAX_DELAY     = 16;
    localparam int DEFAULT_DELAY = 10;
    localparam int DLY_W         = $clog2(MAX_DELAY + 1);
    localparam int DW            = WIDTH * CHANNELS;

    logic             CLK        = 1'b0;
    logic             RESET      = 1'b1;
    logic [DW-1:0]    DIN        = '0;
    logic             DIN_VALID  = 1'b0;
    logic [DLY_W-1:0] DELAY_SET  = '0;
    logic             DELAY_LOAD = 1'b0;
`ifdef DELAY_BYPASS_EN
    logic             BYPASS     = 1'b0;
`endif
    logic             DELAY_ACK;
    logic [DW-1:0]    DOUT;
    logic             DOUT_VALID;
    logic [DLY_W-1:0] DELAY_CUR;
    logic             BUSY;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int exp_d    = DEFAULT_DELAY;

    // sent_*[e] is the input sampled by rising edge number e
    logic [DW-1:0] sent_din [0:4095];
    logic          sent_val [0:4095];

    always #5 CLK = ~CLK;

    multi_channel_programmable_delay #(
        .WIDTH        (WIDTH),
        .CHANNELS     (CHANNELS),
        .MAX_DELAY    (MAX_DELAY),
        .DEFAULT_DELAY(DEFAULT_DELAY)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .DELAY_SET (DELAY_SET),
        .DELAY_LOAD(DELAY_LOAD),
`ifdef DELAY_BYPASS_EN
        .BYPASS    (BYPASS),
`endif
        .DELAY_ACK (DELAY_ACK),
        .DOUT      (DOUT),
        .DOUT_VALID(DOUT_VALID),
        .DELAY_CUR (DELAY_CUR),
        .BUSY      (BUSY)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
        edge_n++;
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic v);
        DIN       = d;
        DIN_VALID = v;
        sent_din[edge_n + 1] = d;
        sent_val[edge_n + 1] = v;
    endtask

    function automatic logic [DW-1:0] pat_din(input int e);
        return {8'(e * 7 + 3), 8'(e * 13 + 1)};
    endfunction

    function automatic logic pat_val(input int e);
        return (e % 4) != 1;
    endfunction

    task automatic test_reset();
        RESET = 1'b1;
        drive('0, 1'b0);
        tick();
        tick();
        checks++;
        if ({DOUT_VALID, DOUT} !== '0) begin
            failures++;
            $display("FAIL reset_dout got=%h exp=0", {DOUT_VALID, DOUT});
        end
        checks++;
        if (DELAY_ACK !== 1'b0) begin
            failures++;
            $display("FAIL reset_ack got=%b exp=0", DELAY_ACK);
        end
        checks++;
        if (DELAY_CUR !== DLY_W'(10)) begin
            failures++;
            $display("FAIL reset_cur got=%0d exp=10", DELAY_CUR);
        end
        checks++;
        if (BUSY !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=1", BUSY);
        end
    endtask

    task automatic test_ramp();
        logic [DW-1:0] exp_dout;
        RESET = 1'b0;
        exp_d = 10;
        for (int i = 0; i < 40; i++) begin
            drive({8'(255 - i), 8'(i)}, 1'b1);
            tick();
            if (i < 10) begin
                checks++;
                if ({DOUT_VALID, DOUT} !== '0) begin
                    failures++;
                    $display("FAIL ramp_flush i=%0d got=%h exp=0", i, {DOUT_VALID, DOUT});
                end
            end else begin
                exp_dout = {8'(255 - (i - 10)), 8'(i - 10)};
                checks++;
                if ({DOUT_VALID, DOUT} !== {1'b1, exp_dout}) begin
                    failures++;
                    $display("FAIL ramp_data i=%0d got=%h exp=%h", i, {DOUT_VALID, DOUT}, {1'b1, exp_dout});
                end
            end
            checks++;
            if (BUSY !== (i < 9)) begin
                failures++;
                $display("FAIL ramp_busy i=%0d got=%b exp=%b", i, BUSY, (i < 9));
            end
        end
    endtask

    task automatic test_valid_pattern();
        for (int j = 0; j < 30; j++) begin
            drive({8'(j + 100), 8'(j * 5)}, (j % 3) == 0);
            tick();
            checks++;
            if ({DOUT_VALID, DOUT} !== {sent_val[edge_n - 10], sent_din[edge_n - 10]}) begin
                failures++;
                $display("FAIL valid_pattern j=%0d got=%h exp=%h", j, {DOUT_VALID, DOUT},
                         {sent_val[edge_n - 10], sent_din[edge_n - 10]});
            end
        end
    endtask

    task automatic test_delay_change(input int set, input int exp_cur, input int run_cycles);
        int old_d;
        old_d      = exp_d;
        DELAY_SET  = DLY_W'(set);
        DELAY_LOAD = 1'b1;
        drive(pat_din(edge_n + 1), pat_val(edge_n + 1));
        tick();
        checks++;
        if ({DELAY_ACK, BUSY, DELAY_CUR} !== {1'b1, 1'b1, DLY_W'(exp_cur)}) begin
            failures++;
            $display("FAIL chg%0d_ack ack/busy/cur got=%b/%b/%0d exp=1/1/%0d", set, DELAY_ACK, BUSY, DELAY_CUR, exp_cur);
        end
        checks++;
        if ({DOUT_VALID, DOUT} !== {sent_val[edge_n - old_d], sent_din[edge_n - old_d]}) begin
            failures++;
            $display("FAIL chg%0d_ackedge_data got=%h exp=%h", set, {DOUT_VALID, DOUT},
                     {sent_val[edge_n - old_d], sent_din[edge_n - old_d]});
        end
        DELAY_LOAD = 1'b0;
        exp_d      = exp_cur;
        for (int k = 1; k <= exp_cur; k++) begin
            drive(pat_din(edge_n + 1), pat_val(edge_n + 1));
            tick();
            checks++;
            if ({DELAY_ACK, DOUT_VALID, DOUT} !== '0 || BUSY !== (k < exp_cur)) begin
                failures++;
                $display("FAIL chg%0d_flush k=%0d ack/dout/busy got=%b/%h/%b exp=0/0/%b", set, k,
                         DELAY_ACK, {DOUT_VALID, DOUT}, BUSY, (k < exp_cur));
            end
        end
        for (int k = 0; k < run_cycles; k++) begin
            drive(pat_din(edge_n + 1), pat_val(edge_n + 1));
            tick();
            checks++;
            if ({DOUT_VALID, DOUT} !== {sent_val[edge_n - exp_d], sent_din[edge_n - exp_d]} ||
                BUSY !== 1'b0 || DELAY_ACK !== 1'b0) begin
                failures++;
                $display("FAIL chg%0d_run k=%0d dout/busy/ack got=%h/%b/%b exp=%h/0/0", set, k,
                         {DOUT_VALID, DOUT}, BUSY, DELAY_ACK,
                         {sent_val[edge_n - exp_d], sent_din[edge_n - exp_d]});
            end
        end
    endtask

    task automatic test_load_pending();
        DELAY_SET  = DLY_W'(6);
        DELAY_LOAD = 1'b1;
        drive(pat_din(edge_n + 1), pat_val(edge_n + 1));
        tick();
        checks++;
        if (DELAY_ACK !== 1'b1 || DELAY_CUR !== DLY_W'(6)) begin
            failures++;
            $display("FAIL pend_first_ack ack/cur got=%b/%0d exp=1/6", DELAY_ACK, DELAY_CUR);
        end
        DELAY_SET = DLY_W'(3);
        for (int k = 1; k <= 6; k++) begin
            drive(pat_din(edge_n + 1), pat_val(edge_n + 1));
            tick();
            checks++;
            if (DELAY_ACK !== 1'b0 || DOUT_VALID !== 1'b0 || BUSY !== (k < 6) || DELAY_CUR !== DLY_W'(6)) begin
                failures++;
                $display("FAIL pend_flush k=%0d ack/valid/busy/cur got=%b/%b/%b/%0d exp=0/0/%b/6", k,
                         DELAY_ACK, DOUT_VALID, BUSY, DELAY_CUR, (k < 6));
            end
        end
        drive(pat_din(edge_n + 1), pat_val(edge_n + 1));
        tick();
        checks++;
        if ({DELAY_ACK, BUSY, DELAY_CUR} !== {1'b1, 1'b1, DLY_W'(3)}) begin
            failures++;
            $display("FAIL pend_second_ack ack/busy/cur got=%b/%b/%0d exp=1/1/3", DELAY_ACK, BUSY, DELAY_CUR);
        end
        checks++;
        if ({DOUT_VALID, DOUT} !== {sent_val[edge_n - 6], sent_din[edge_n - 6]}) begin
            failures++;
            $display("FAIL pend_run_data got=%h exp=%h", {DOUT_VALID, DOUT}, {sent_val[edge_n - 6], sent_din[edge_n - 6]});
        end
        DELAY_LOAD = 1'b0;
        exp_d      = 3;
        for (int k = 1; k <= 3; k++) begin
            drive(pat_din(edge_n + 1), pat_val(edge_n + 1));
            tick();
            checks++;
            if (DOUT_VALID !== 1'b0 || DELAY_ACK !== 1'b0 || BUSY !== (k < 3)) begin
                failures++;
                $display("FAIL pend_flush2 k=%0d valid/ack/busy got=%b/%b/%b exp=0/0/%b", k, DOUT_VALID, DELAY_ACK, BUSY, (k < 3));
            end
        end
        for (int k = 0; k < 10; k++) begin
            drive(pat_din(edge_n + 1), pat_val(edge_n + 1));
            tick();
            checks++;
            if ({DOUT_VALID, DOUT} !== {sent_val[edge_n - 3], sent_din[edge_n - 3]}) begin
                failures++;
                $display("FAIL pend_run3 k=%0d got=%h exp=%h", k, {DOUT_VALID, DOUT}, {sent_val[edge_n - 3], sent_din[edge_n - 3]});
            end
        end
    endtask

    task automatic test_reset_midflush();
        DELAY_SET  = DLY_W'(8);
        DELAY_LOAD = 1'b1;
        drive(pat_din(edge_n + 1), pat_val(edge_n + 1));
        tick();
        DELAY_LOAD = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(pat_din(edge_n + 1), 1'b1);
            tick();
        end
        RESET = 1'b1;
        #2;
        checks++;
        if ({DOUT_VALID, DOUT} !== '0 || DELAY_CUR !== DLY_W'(10) || BUSY !== 1'b1 || DELAY_ACK !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async dout/cur/busy/ack got=%h/%0d/%b/%b exp=0/10/1/0",
                     {DOUT_VALID, DOUT}, DELAY_CUR, BUSY, DELAY_ACK);
        end
        tick();
        RESET = 1'b0;
        exp_d = 10;
        for (int i = 0; i < 20; i++) begin
            drive(pat_din(edge_n + 1), 1'b1);
            tick();
            checks++;
            if (i < 10) begin
                if ({DOUT_VALID, DOUT} !== '0 || BUSY !== (i < 9)) begin
                    failures++;
                    $display("FAIL midreset_flush i=%0d dout/busy got=%h/%b exp=0/%b", i, {DOUT_VALID, DOUT}, BUSY, (i < 9));
                end
            end else begin
                if ({DOUT_VALID, DOUT} !== {sent_val[edge_n - 10], sent_din[edge_n - 10]}) begin
                    failures++;
                    $display("FAIL midreset_run i=%0d got=%h exp=%h", i, {DOUT_VALID, DOUT},
                             {sent_val[edge_n - 10], sent_din[edge_n - 10]});
                end
            end
        end
    endtask

`ifdef DELAY_BYPASS_EN
    task automatic test_bypass();
        BYPASS     = 1'b1;
        DELAY_SET  = DLY_W'(10);
        DELAY_LOAD = 1'b1;
        drive(pat_din(edge_n + 1), pat_val(edge_n + 1));
        tick();
        DELAY_LOAD = 1'b0;
        checks++;
        if (DELAY_ACK !== 1'b1 || DELAY_CUR !== DLY_W'(10)) begin
            failures++;
            $display("FAIL bypass_ack ack/cur got=%b/%0d exp=1/10", DELAY_ACK, DELAY_CUR);
        end
        for (int k = 1; k <= 10; k++) begin
            drive(pat_din(edge_n + 1), pat_val(edge_n + 1));
            tick();
            checks++;
            if ({DOUT_VALID, DOUT} !== {sent_val[edge_n], sent_din[edge_n]} || BUSY !== (k < 10)) begin
                failures++;
                $display("FAIL bypass_data k=%0d dout/busy got=%h/%b exp=%h/%b", k, {DOUT_VALID, DOUT}, BUSY,
                         {sent_val[edge_n], sent_din[edge_n]}, (k < 10));
            end
        end
        BYPASS = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(pat_din(edge_n + 1), pat_val(edge_n + 1));
            tick();
            checks++;
            if ({DOUT_VALID, DOUT} !== {sent_val[edge_n - 10], sent_din[edge_n - 10]} || BUSY !== 1'b0) begin
                failures++;
                $display("FAIL bypass_resume k=%0d dout/busy got=%h/%b exp=%h/0", k, {DOUT_VALID, DOUT}, BUSY,
                         {sent_val[edge_n - 10], sent_din[edge_n - 10]});
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ramp();
        test_valid_pattern();
        test_delay_change(4, 4, 12);
        test_delay_change(0, 1, 8);
        test_delay_change(31, 16, 50);
        test_load_pending();
        test_reset_midflush();
        test_delay_change(10, 10, 12);
`ifdef DELAY_BYPASS_EN
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
